// File: rtl/double_eq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : double_eq_pkg
// Purpose  : Shared constants, response-tag type and small helpers for the
//            double_eq comparator arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package double_eq_pkg;

  // Width of one IEEE-754 double operand.
  localparam int OPERAND_W = 64;

  // Largest supported requester count. Tag indices are sized for this so the
  // tag type can be shared by every configuration; the top only ever
  // compares or decodes indices below its own N_REQ.
  localparam int N_REQ_MAX = 8;
  localparam int IDX_W     = $clog2(N_REQ_MAX);

  // Tag that follows an operand pair through the comparator latency.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  // Convert a one-hot (or all-zero) grant vector to a binary index.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ_MAX-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ_MAX; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  // Advance a round-robin index, wrapping at n.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin grant. Picks the first set request at
//            or after ptr, wrapping modulo N; grant is one-hot or zero.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import double_eq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [N-1:0]   rot_req;
  logic [N-1:0]   first;
  logic [2*N-1:0] rot_grant;

  // Rotate so ptr sits at bit 0; the lowest set bit is then the winner.
  assign rot_req   = N'({req, req} >> ptr);
  assign first     = rot_req & (~rot_req + N'(1));

  // Rotate the winner back into requester numbering, folding the wrap.
  assign rot_grant = {{N{1'b0}}, first} << ptr;
  assign grant     = rot_grant[N-1:0] | rot_grant[2*N-1:N];

endmodule
`default_nettype wire

// File: rtl/double_eq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : double_eq_arbiter
// Purpose  : Shares one external pipelined double-equality comparator between
//            N_REQ requesters. Round-robin issue, one outstanding operation
//            per requester, per-requester held responses.
// Options  : DOUBLE_EQ_ARBITER_PERF_EN - adds a 32-bit issue_count output.
// Revision : 1.0 - initial release
// ============================================================================
module double_eq_arbiter
  import double_eq_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CMP_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [64*N_REQ-1:0]    req_a,
  input  logic [64*N_REQ-1:0]    req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [N_REQ-1:0]       rsp_z,
  output logic [OPERAND_W-1:0]   cmp_a,
  output logic [OPERAND_W-1:0]   cmp_b,
  input  logic                   cmp_z
`ifdef DOUBLE_EQ_ARBITER_PERF_EN
  ,
  output logic [31:0]            issue_count
`endif
);

  localparam int OP_SHIFT = $clog2(OPERAND_W);

  logic [N_REQ-1:0]     outstanding;
  logic [N_REQ-1:0]     eligible;
  logic [N_REQ-1:0]     grant;
  logic                 accept;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     acc_idx;
  logic [OPERAND_W-1:0] sel_a;
  logic [OPERAND_W-1:0] sel_b;
  tag_t                 tag_in;
  tag_t                 tag_out;
  tag_t                 tag_pipe [CMP_LAT+1];

  // A requester competes only while it has nothing in flight or undelivered.
  assign eligible = req_valid & ~outstanding;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .req   (eligible),
    .ptr   (ptr),
    .grant (grant)
  );

  // Grant is already qualified by req_valid, so any ready bit is an accept.
  assign req_ready = rst ? '0 : grant;
  assign accept    = |req_ready;
  assign acc_idx   = onehot_to_idx(N_REQ_MAX'(grant));

  // Select the granted operand slice by shifting it down to bit 0.
  assign sel_a = OPERAND_W'(req_a >> {acc_idx, {OP_SHIFT{1'b0}}});
  assign sel_b = OPERAND_W'(req_b >> {acc_idx, {OP_SHIFT{1'b0}}});

  assign tag_in  = '{valid: accept, idx: acc_idx};
  assign tag_out = tag_pipe[CMP_LAT];

  // Operand registers and round-robin pointer advance only on an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_a <= '0;
      cmp_b <= '0;
      ptr   <= '0;
    end else if (accept) begin
      cmp_a <= sel_a;
      cmp_b <= sel_b;
      ptr   <= wrap_inc(acc_idx, N_REQ);
    end
  end

  // Stage 0 travels alongside the operand register; stages 1..CMP_LAT track
  // the comparator, so the last stage lines up with a valid cmp_z.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= CMP_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int k = 1; k <= CMP_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  // Per-requester response holding and outstanding-operation tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= '0;
      rsp_z       <= '0;
      outstanding <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (tag_out.valid && (tag_out.idx == IDX_W'(i))) begin
          rsp_valid[i] <= 1'b1;
          rsp_z[i]     <= cmp_z;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end

        // Cleared only by the response handshake, so a same-cycle new
        // request from that requester waits one more cycle.
        if (req_ready[i]) begin
          outstanding[i] <= 1'b1;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          outstanding[i] <= 1'b0;
        end
      end
    end
  end

`ifdef DOUBLE_EQ_ARBITER_PERF_EN
  // Free-running count of accepted operations, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_count <= '0;
    end else if (accept) begin
      issue_count <= issue_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_double_eq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_double_eq_arbiter
// Purpose  : Self-checking bench for double_eq_arbiter with a comparator model
//            and a transaction-level reference of grants and responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_double_eq_arbiter;

  localparam int N   = 4;
  localparam int LAT = 1;
  localparam int W   = 64;

  localparam logic [W-1:0] ONE   = 64'h3FF0000000000000;
  localparam logic [W-1:0] TWO   = 64'h4000000000000000;
  localparam logic [W-1:0] NZERO = 64'h8000000000000000;
  localparam logic [W-1:0] QNAN  = 64'h7FF8000000000000;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready, rsp_z;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   cmp_a, cmp_b;
  logic           cmp_z;
`ifdef DOUBLE_EQ_ARBITER_PERF_EN
  logic [31:0]    issue_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  double_eq_arbiter #(.N_REQ(N), .CMP_LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_z       (rsp_z),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .cmp_z       (cmp_z)
`ifdef DOUBLE_EQ_ARBITER_PERF_EN
    ,
    .issue_count (issue_count)
`endif
  );

  // IEEE-754 equality: NaN never equal, +0 equals -0.
  function automatic bit feq(input logic [W-1:0] a, input logic [W-1:0] b);
    bit a_nan, b_nan;
    a_nan = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
    b_nan = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
    if (a_nan || b_nan) return 1'b0;
    if ((a[62:0] == 0) && (b[62:0] == 0)) return 1'b1;
    return a === b;
  endfunction

  // External comparator model with LAT-edge latency.
  logic cz [LAT];
  always @(posedge clk) begin
    cz[0] <= feq(cmp_a, cmp_b);
    for (int k = 1; k < LAT; k++) cz[k] <= cz[k-1];
  end
  assign cmp_z = cz[LAT-1];

  // ---------------- reference model ----------------
  typedef struct { int idx; bit z; int left; } flight_t;
  flight_t      fl[$];
  int           m_ptr;
  logic [N-1:0] m_out, m_rv, m_rz;
  logic [W-1:0] m_ca, m_cb;

  function automatic int m_grant();
    if (rst) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j] && !m_out[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = m_grant();
    return (g < 0) ? '0 : N'(1 << g);
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    int g;
    logic [W-1:0] a, b;
    g = m_grant();
    a = '0;
    b = '0;
    if (g >= 0) begin
      a = req_a[g*W +: W];
      b = req_b[g*W +: W];
    end
    @(posedge clk);
    if (rst) begin
      fl.delete();
      m_ptr = 0; m_out = '0; m_rv = '0; m_rz = '0; m_ca = '0; m_cb = '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (m_rv[i] && rsp_ready[i]) begin m_rv[i] = 1'b0; m_out[i] = 1'b0; end
      foreach (fl[q]) fl[q].left--;
      while (fl.size() > 0 && fl[0].left == 0) begin
        m_rv[fl[0].idx] = 1'b1;
        m_rz[fl[0].idx] = fl[0].z;
        void'(fl.pop_front());
      end
      if (g >= 0) begin
        fl.push_back('{idx: g, z: feq(a, b), left: LAT + 1});
        m_out[g] = 1'b1;
        m_ptr    = (g + 1) % N;
        m_ca     = a;
        m_cb     = b;
      end
    end
    #1;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom % 6)
      0: return ONE;
      1: return TWO;
      2: return '0;
      3: return NZERO;
      4: return QNAN;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic set_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = rand_op();
      req_b[i*W +: W] = ($urandom % 2 == 0) ? req_a[i*W +: W] : rand_op();
    end
  endtask

  task automatic drain();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (6) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    set_ops();
    tick();
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if ({req_ready, rsp_valid, rsp_z} !== '0 || cmp_a !== '0 || cmp_b !== '0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d ready/rv/rz=%b/%b/%b cmp_a=%h cmp_b=%h required all zero",
                 c, req_ready, rsp_valid, rsp_z, cmp_a, cmp_b);
      end
      tick();
    end
    rst = 1'b0;
    #2;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL first_grant got=%b required=0001", req_ready);
    end
    tick();
  endtask

  task automatic test_single();
    drain();
    req_valid = 4'b0001;
    req_a[0 +: W] = ONE;
    req_b[0 +: W] = ONE;
    rsp_ready = '0;
    #2;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant got=%b required=0001", req_ready);
    end
    tick();
    req_valid = '0;
    for (int e = 1; e <= 2; e++) begin
      #2;
      checks++;
      if (rsp_valid[0] !== 1'b0 || cmp_a !== ONE) begin
        errors++;
        $display("FAIL single_early edge=%0d rsp_valid0=%b cmp_a=%h required 0 and %h", e, rsp_valid[0], cmp_a, ONE);
      end
      tick();
    end
    #2;
    checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_z[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_rsp rsp_valid0=%b rsp_z0=%b required 1 1", rsp_valid[0], rsp_z[0]);
    end
    rsp_ready = '1;
    tick();
  endtask

  task automatic test_round_robin();
    int accepts;
    drain();
    accepts = 0;
    req_valid = '1;
    for (int c = 0; c < 40; c++) begin
      set_ops();
      #2;
      if (|req_ready) accepts++;
      checks++;
      if ({req_ready, rsp_valid, rsp_z} !== {exp_ready(), m_rv, m_rz} || cmp_a !== m_ca || cmp_b !== m_cb) begin
        errors++;
        $display("FAIL rr_cycle c=%0d ready/rv/rz=%b/%b/%b required %b/%b/%b cmp_a=%h required %h",
                 c, req_ready, rsp_valid, rsp_z, exp_ready(), m_rv, m_rz, cmp_a, m_ca);
      end
      tick();
    end
    checks++;
    if (accepts != 40) begin
      errors++;
      $display("FAIL rr_throughput accepts=%0d required=40", accepts);
    end
  endtask

  task automatic test_back_pressure();
    int accepts;
    int waited;
    drain();
    req_valid = '1;
    rsp_ready = 4'b1011;
    waited = 0;
    while (!m_rv[2] && waited < 12) begin
      set_ops();
      tick();
      waited++;
    end
    checks++;
    if (!m_rv[2]) begin
      errors++;
      $display("FAIL bp_setup response for requester 2 not reached within %0d cycles", waited);
    end
    accepts = 0;
    for (int c = 0; c < 10; c++) begin
      set_ops();
      #2;
      if (|req_ready) accepts++;
      checks++;
      if (rsp_valid[2] !== 1'b1 || rsp_z[2] !== m_rz[2] || req_ready[2] !== 1'b0 ||
          {req_ready, rsp_valid, rsp_z} !== {exp_ready(), m_rv, m_rz}) begin
        errors++;
        $display("FAIL bp_hold c=%0d ready/rv/rz=%b/%b/%b required %b/%b/%b",
                 c, req_ready, rsp_valid, rsp_z, exp_ready(), m_rv, m_rz);
      end
      tick();
    end
    checks++;
    if (accepts < 7) begin
      errors++;
      $display("FAIL bp_others accepts=%0d required>=7", accepts);
    end
    rsp_ready = '1;
  endtask

  task automatic test_reset_inflight();
    drain();
    rsp_ready = '0;
    req_valid = 4'b0010;
    req_a[W +: W] = ONE;
    req_b[W +: W] = TWO;
    tick();
    req_valid = '0;
    tick();
    tick();
    #2;
    checks++;
    if (rsp_valid[1] !== 1'b1 || rsp_z[1] !== 1'b0) begin
      errors++;
      $display("FAIL ne_rsp rsp_valid1=%b rsp_z1=%b required 1 0", rsp_valid[1], rsp_z[1]);
    end
    rsp_ready = '1;
    tick();
    req_valid = 4'b0010;
    #2;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL reissue_grant got=%b required=0010", req_ready);
    end
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if (rsp_valid !== '0) begin
        errors++;
        $display("FAIL flush c=%0d rsp_valid=%b required=0000", c, rsp_valid);
      end
      tick();
    end
  endtask

  task automatic test_random();
    drain();
    for (int c = 0; c < 300; c++) begin
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      rst = ($urandom % 40 == 0);
      set_ops();
      #2;
      checks++;
      if ({req_ready, rsp_valid, rsp_z} !== {exp_ready(), m_rv, m_rz} || cmp_a !== m_ca || cmp_b !== m_cb) begin
        errors++;
        $display("FAIL rand_cycle c=%0d ready/rv/rz=%b/%b/%b required %b/%b/%b cmp_a=%h required %h",
                 c, req_ready, rsp_valid, rsp_z, exp_ready(), m_rv, m_rz, cmp_a, m_ca);
      end
      tick();
    end
    rst = 1'b0;
  endtask

`ifdef DOUBLE_EQ_ARBITER_PERF_EN
  task automatic test_perf();
    int n;
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    #2;
    checks++;
    if (issue_count !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset got=%0d required=0", issue_count);
    end
    n = 0;
    req_valid = '1;
    rsp_ready = '1;
    for (int c = 0; c < 300 && n < 100; c++) begin
      #2;
      if (|exp_ready()) n++;
      tick();
    end
    req_valid = '0;
    #2;
    checks++;
    if (issue_count !== 32'd100) begin
      errors++;
      $display("FAIL perf_count got=%0d required=100", issue_count);
    end
    drain();
    force dut.issue_count = 32'hFFFFFFFF;
    #1;
    release dut.issue_count;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    #2;
    checks++;
    if (issue_count !== 32'd0) begin
      errors++;
      $display("FAIL perf_wrap got=%h required=00000000", issue_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    m_ptr = 0; m_out = '0; m_rv = '0; m_rz = '0; m_ca = '0; m_cb = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_reset_inflight();
    test_random();
`ifdef DOUBLE_EQ_ARBITER_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
